// File: rtl/accel_pkg.sv
// Opcode values and engine state encoding shared by the accelerator engine and its bench.
package accel_pkg;

    localparam logic [3:0] OP_NOP  = 4'h0;
    localparam logic [3:0] OP_SHL  = 4'h1;
    localparam logic [3:0] OP_CLR  = 4'h2;
    localparam logic [3:0] OP_ST   = 4'h3;
    localparam logic [3:0] OP_STI  = 4'h4;
    localparam logic [3:0] OP_JMP  = 4'h5;
    localparam logic [3:0] OP_HALT = 4'hF;

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        EXEC,
        DRAIN,
        DONE
    } state_e;

endpackage

// File: rtl/accel_fifo.sv
// Output FIFO between the engine and the memory write port; the head entry is read
// straight from registered storage so it stays stable while the consumer stalls.
module accel_fifo #(
    parameter int WIDTH = 48,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic             full,
    output logic             empty,
    output logic [WIDTH-1:0] head
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW:0]      count_q, count_d;
    logic             do_push, do_pop;

    // NOTE: every combinational output gets a default first so no path infers a latch.
    always_comb begin
        full     = (count_q == FULL_CNT);
        empty    = (count_q == '0);
        head     = mem_q[rd_ptr_q];
        do_push  = push && !full;
        do_pop   = pop && !empty;
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
        if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + (AW+1)'(1);
            2'b01:   count_d = count_q - (AW+1)'(1);
            default: count_d = count_q;
        endcase
    end

    // NOTE: state is updated with non-blocking assignments so every flop samples pre-edge values.
    // NOTE: storage is reset too, so the head port reads zero while reset is held.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
            if (do_push) mem_q[wr_ptr_q] <= push_data;
        end
    end

endmodule

// File: rtl/accel_engine.sv
// Fetch / assemble / execute engine: reads multi-word instructions from a combinational
// ROM, builds immediates in a data register and queues stores toward the memory port.
module accel_engine
    import accel_pkg::*;
#(
    parameter int ROM_AW     = 8,
    parameter int ROM_DW     = 8,
    parameter int IW         = 16,
    parameter int MEM_AW     = 16,
    parameter int MEM_DW     = 32,
    parameter int FIFO_DEPTH = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    output logic [ROM_AW-1:0] rom_addr,
    input  logic [ROM_DW-1:0] rom_data,
    output logic              mem_valid,
    input  logic              mem_ready,
    output logic [MEM_AW-1:0] mem_addr,
    output logic [MEM_DW-1:0] mem_wdata,
    output logic              busy,
    output logic              done,
    output logic              error,
    output logic [15:0]       instr_count
);

    localparam int K   = IW / ROM_DW;
    localparam int OW  = IW - 4;
    localparam int WCW = (K > 1) ? $clog2(K) : 1;
    localparam logic [WCW-1:0]    LAST_WORD = WCW'(K - 1);
    localparam logic [ROM_AW-1:0] PC_STEP   = ROM_AW'(K);

    state_e              state_q, state_d;
    logic [ROM_AW-1:0]   pc_q, pc_d;
    logic [WCW-1:0]      word_q, word_d;
    logic [IW-1:0]       instr_q, instr_d;
    logic [MEM_DW-1:0]   data_q, data_d;
    logic                error_q, error_d;
    logic [15:0]         count_q, count_d;

    logic [3:0]          opcode;
    logic [OW-1:0]       operand;
    logic                retire;
    logic                fifo_push, fifo_full, fifo_empty;
    logic [MEM_AW+MEM_DW-1:0] fifo_head;

    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        word_d    = word_q;
        instr_d   = instr_q;
        data_d    = data_q;
        error_d   = error_q;
        count_d   = count_q;
        retire    = 1'b0;
        fifo_push = 1'b0;
        done      = 1'b0;
        rom_addr  = pc_q;
        opcode    = instr_q[IW-1 -: 4];
        operand   = instr_q[OW-1:0];

        unique case (state_q)
            IDLE: begin
                if (start) begin
                    pc_d    = '0;
                    word_d  = '0;
                    data_d  = '0;
                    error_d = 1'b0;
                    count_d = '0;
                    state_d = FETCH;
                end
            end
            FETCH: begin
                // Earlier words shift toward the top, so the first word ends up most significant.
                rom_addr = pc_q + ROM_AW'(word_q);
                instr_d  = (instr_q << ROM_DW) | IW'(rom_data);
                if (word_q == LAST_WORD) begin
                    word_d  = '0;
                    state_d = EXEC;
                end else begin
                    word_d = word_q + WCW'(1);
                end
            end
            EXEC: begin
                retire  = 1'b1;
                state_d = FETCH;
                pc_d    = pc_q + PC_STEP;
                case (opcode)
                    OP_NOP: ;
                    OP_SHL: data_d = (data_q << OW) | MEM_DW'(operand);
                    OP_CLR: data_d = '0;
                    OP_ST, OP_STI: begin
                        if (fifo_full) begin
                            retire  = 1'b0;
                            state_d = EXEC;
                            pc_d    = pc_q;
                        end else begin
                            fifo_push = 1'b1;
                            if (opcode == OP_STI) data_d = data_q + MEM_DW'(1);
                        end
                    end
                    OP_JMP:  pc_d = ROM_AW'(operand);
                    OP_HALT: state_d = DRAIN;
                    default: begin
                        error_d = 1'b1;
                        state_d = DRAIN;
                    end
                endcase
                if (retire) count_d = count_q + 16'd1;
            end
            DRAIN: begin
                if (fifo_empty) state_d = DONE;
            end
            DONE: begin
                done    = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            pc_q    <= '0;
            word_q  <= '0;
            instr_q <= '0;
            data_q  <= '0;
            error_q <= 1'b0;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            word_q  <= word_d;
            instr_q <= instr_d;
            data_q  <= data_d;
            error_q <= error_d;
            count_q <= count_d;
        end
    end

    accel_fifo #(
        .WIDTH (MEM_AW + MEM_DW),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (fifo_push),
        .push_data ({MEM_AW'(operand), data_q}),
        .pop       (mem_valid && mem_ready),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .head      (fifo_head)
    );

    assign mem_valid               = !fifo_empty;
    assign {mem_addr, mem_wdata}   = fifo_head;
    assign busy                    = (state_q != IDLE);
    assign error                   = error_q;
    assign instr_count             = count_q;

endmodule

// File: tb/tb_accel_engine.sv
// Bench for accel_engine: table-driven programs, hand-written corner sequences and
// random programs checked against an instruction-level interpreter of the ROM.
module tb_accel_engine;
    import accel_pkg::*;

    typedef struct {
        string       name;
        logic [15:0] prog [8];
        int          n_wr;
        logic [47:0] first_wr;
        logic [47:0] last_wr;
        logic [15:0] cnt;
        logic        err;
    } vec_t;

    localparam int NV = 7;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        start = 1'b0;
    logic        mem_ready = 1'b0;
    logic [7:0]  rom_addr, rom_data;
    logic        mem_valid, busy, done, error;
    logic [15:0] mem_addr, instr_count;
    logic [31:0] mem_wdata;

    logic [7:0]  rom [256];
    vec_t        vecs [NV];
    logic [47:0] wr_q [$];
    logic [47:0] exp_q [$];
    int          checks = 0;
    int          errors = 0;
    int          done_total = 0;
    int          wr_base = 0;
    int          done_base = 0;
    bit          rand_ready = 1'b0;
    logic        stall_prev = 1'b0;
    logic [47:0] head_prev = '0;

    always #5 clk = ~clk;
    assign rom_data = rom[rom_addr];

    accel_engine #(
        .ROM_AW(8), .ROM_DW(8), .IW(16), .MEM_AW(16), .MEM_DW(32), .FIFO_DEPTH(4)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .rom_addr    (rom_addr),
        .rom_data    (rom_data),
        .mem_valid   (mem_valid),
        .mem_ready   (mem_ready),
        .mem_addr    (mem_addr),
        .mem_wdata   (mem_wdata),
        .busy        (busy),
        .done        (done),
        .error       (error),
        .instr_count (instr_count)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Writes are recorded at the falling edge before the rising edge that accepts them.
    always @(negedge clk) begin
        if (!reset) begin
            stall_prev <= 1'b0;
        end else begin
            if (done) done_total <= done_total + 1;
            if (mem_valid && mem_ready) wr_q.push_back({mem_addr, mem_wdata});
            if (stall_prev) begin
                check("stall_valid", 64'(mem_valid), 64'd1);
                check("stall_head", 64'({mem_addr, mem_wdata}), 64'(head_prev));
            end
            stall_prev <= mem_valid && !mem_ready;
            head_prev  <= {mem_addr, mem_wdata};
        end
    end

    function automatic logic [47:0] get_wr(input int idx);
        if (idx < wr_q.size()) return wr_q[idx];
        return 'x;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
        if (rand_ready) mem_ready = 1'($urandom_range(0, 1));
    endtask

    task automatic clear_rom();
        for (int a = 0; a < 256; a++) rom[a] = 8'hF0;
    endtask

    task automatic put_word(input logic [7:0] addr, input logic [15:0] w);
        rom[addr]         = w[15:8];
        rom[8'(addr + 1)] = w[7:0];
    endtask

    task automatic start_run();
        wr_base   = wr_q.size();
        done_base = done_total;
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_done(input string name, input int budget);
        bit seen = 1'b0;
        for (int i = 0; i < budget && !seen; i++) begin
            tick();
            seen = done;
        end
        if (!seen) check({name, "_timeout"}, 64'd0, 64'd1);
        tick();
    endtask

    // Instruction-level interpreter of the ROM contents.
    task automatic model_run(output int cnt, output bit err);
        logic [7:0]  pc = 8'd0;
        logic [31:0] data = 32'd0;
        logic [15:0] w;
        exp_q.delete();
        cnt = 0;
        err = 1'b0;
        for (int s = 0; s < 500; s++) begin
            w = {rom[pc], rom[8'(pc + 1)]};
            cnt++;
            case (w[15:12])
                OP_NOP:  ;
                OP_SHL:  data = (data << 12) | 32'(w[11:0]);
                OP_CLR:  data = 32'd0;
                OP_ST:   exp_q.push_back({16'(w[11:0]), data});
                OP_STI:  begin exp_q.push_back({16'(w[11:0]), data}); data = data + 32'd1; end
                OP_JMP:  begin pc = w[7:0]; continue; end
                OP_HALT: return;
                default: begin err = 1'b1; return; end
            endcase
            pc = pc + 8'd2;
        end
    endtask

    initial begin
        int  n, ecnt;
        bit  eerr, hit;
        logic [3:0]  op;
        logic [11:0] opd;

        vecs[0] = '{"basic", '{16'h2000, 16'h1ABC, 16'h1DEF, 16'h3010, 16'hF000, 16'hF000, 16'hF000, 16'hF000},
                    1, 48'h0010_00ABCDEF, 48'h0010_00ABCDEF, 16'd5, 1'b0};
        vecs[1] = '{"illegal", '{16'h7123, 16'h3001, 16'hF000, 16'hF000, 16'hF000, 16'hF000, 16'hF000, 16'hF000},
                    0, 48'h0, 48'h0, 16'd1, 1'b1};
        vecs[2] = '{"sti_chain", '{16'h2000, 16'h1005, 16'h4002, 16'h4003, 16'h3004, 16'hF000, 16'hF000, 16'hF000},
                    3, 48'h0002_00000005, 48'h0004_00000007, 16'd6, 1'b0};
        vecs[3] = '{"shl_trunc", '{16'h1FFF, 16'h1FFF, 16'h1FFF, 16'h3ABC, 16'hF000, 16'hF000, 16'hF000, 16'hF000},
                    1, 48'h0ABC_FFFFFFFF, 48'h0ABC_FFFFFFFF, 16'd5, 1'b0};
        vecs[4] = '{"sti_wrap", '{16'h2000, 16'h1FFF, 16'h1FFF, 16'h1FFF, 16'h4001, 16'h3002, 16'hF000, 16'hF000},
                    2, 48'h0001_FFFFFFFF, 48'h0002_00000000, 16'd7, 1'b0};
        vecs[5] = '{"jmp_fwd", '{16'h5004, 16'h3001, 16'h2000, 16'h4007, 16'hF000, 16'hF000, 16'hF000, 16'hF000},
                    1, 48'h0007_00000000, 48'h0007_00000000, 16'd4, 1'b0};
        vecs[6] = '{"st_then_bad", '{16'h3005, 16'h8FFF, 16'h3006, 16'hF000, 16'hF000, 16'hF000, 16'hF000, 16'hF000},
                    1, 48'h0005_00000000, 48'h0005_00000000, 16'd2, 1'b1};

        clear_rom();
        #2;
        check("rst_rom_addr", 64'(rom_addr), 64'd0);
        check("rst_mem_valid", 64'(mem_valid), 64'd0);
        check("rst_mem_word", 64'({mem_addr, mem_wdata}), 64'd0);
        check("rst_flags", 64'({busy, done, error}), 64'd0);
        check("rst_count", 64'(instr_count), 64'd0);
        tick();
        tick();
        reset = 1'b1;
        tick();

        // Table-driven programs with mem_ready held high.
        for (int v = 0; v < NV; v++) begin
            clear_rom();
            for (int i = 0; i < 8; i++) put_word(8'(2 * i), vecs[v].prog[i]);
            mem_ready = 1'b1;
            start_run();
            wait_done(vecs[v].name, 200);
            check({vecs[v].name, "_nwr"}, 64'(wr_q.size() - wr_base), 64'(vecs[v].n_wr));
            if (vecs[v].n_wr > 0) begin
                check({vecs[v].name, "_first"}, 64'(get_wr(wr_base)), 64'(vecs[v].first_wr));
                check({vecs[v].name, "_last"}, 64'(get_wr(wr_base + vecs[v].n_wr - 1)), 64'(vecs[v].last_wr));
            end
            check({vecs[v].name, "_count"}, 64'(instr_count), 64'(vecs[v].cnt));
            check({vecs[v].name, "_error"}, 64'(error), 64'(vecs[v].err));
            check({vecs[v].name, "_done"}, 64'(done_total - done_base), 64'd1);
            check({vecs[v].name, "_idle"}, 64'(busy), 64'd0);
        end

        // First write latency: mem_valid in the 13th cycle after the start edge.
        clear_rom();
        for (int i = 0; i < 8; i++) put_word(8'(2 * i), vecs[0].prog[i]);
        mem_ready = 1'b1;
        start_run();
        n = 0;
        hit = 1'b0;
        while (!hit && n < 40) begin
            @(negedge clk);
            n++;
            hit = mem_valid;
        end
        check("lat_cycle", 64'(n), 64'd13);
        wait_done("lat", 100);
        check("lat_count", 64'(instr_count), 64'd5);

        // Illegal opcode sets error; the next accepted start clears it.
        clear_rom();
        for (int i = 0; i < 8; i++) put_word(8'(2 * i), vecs[1].prog[i]);
        start_run();
        wait_done("ill", 100);
        check("ill_error", 64'(error), 64'd1);
        clear_rom();
        for (int i = 0; i < 8; i++) put_word(8'(2 * i), vecs[0].prog[i]);
        start_run();
        check("restart_error", 64'(error), 64'd0);
        check("restart_count", 64'(instr_count), 64'd0);
        check("restart_busy", 64'(busy), 64'd1);
        wait_done("restart", 100);

        // Backpressure: six STI behind a stalled memory port.
        clear_rom();
        put_word(8'd0, 16'h2000);
        for (int i = 1; i <= 6; i++) put_word(8'(2 * i), 16'h4001);
        put_word(8'd14, 16'hF000);
        mem_ready = 1'b0;
        start_run();
        repeat (39) tick();
        check("bp_count", 64'(instr_count), 64'd5);
        check("bp_valid", 64'(mem_valid), 64'd1);
        check("bp_nwr", 64'(wr_q.size() - wr_base), 64'd0);
        check("bp_head", 64'({mem_addr, mem_wdata}), 64'h0001_00000000);
        mem_ready = 1'b1;
        wait_done("bp", 300);
        check("bp_total", 64'(wr_q.size() - wr_base), 64'd6);
        for (int k = 0; k < 6; k++) check("bp_data", 64'(get_wr(wr_base + k)), 64'({16'h0001, 32'(k)}));
        check("bp_final_count", 64'(instr_count), 64'd8);

        // JMP to the top of the ROM, then a jump whose instruction straddles the wrap.
        clear_rom();
        put_word(8'h00, 16'h50FE);
        put_word(8'hFE, 16'hF000);
        start_run();
        wait_done("jmp_fe", 100);
        check("jmp_fe_nwr", 64'(wr_q.size() - wr_base), 64'd0);
        check("jmp_fe_count", 64'(instr_count), 64'd2);
        clear_rom();
        put_word(8'h00, 16'h50FF);
        rom[8'hFF] = 8'h4A;
        start_run();
        wait_done("jmp_ff", 100);
        check("jmp_ff_wr", 64'(get_wr(wr_base)), 64'h0A50_00000000);
        check("jmp_ff_count", 64'(instr_count), 64'd3);

        // Reset mid-run with two entries queued.
        clear_rom();
        put_word(8'd0, 16'h2000);
        put_word(8'd2, 16'h3001);
        put_word(8'd4, 16'h3002);
        put_word(8'd6, 16'h5006);
        mem_ready = 1'b0;
        start_run();
        repeat (20) tick();
        check("mid_valid", 64'(mem_valid), 64'd1);
        reset = 1'b0;
        #1;
        check("mid_rst_valid", 64'(mem_valid), 64'd0);
        check("mid_rst_busy", 64'(busy), 64'd0);
        check("mid_rst_word", 64'({mem_addr, mem_wdata}), 64'd0);
        check("mid_rst_misc", 64'({rom_addr, instr_count}), 64'd0);
        tick();
        reset = 1'b1;
        mem_ready = 1'b1;
        repeat (20) tick();
        check("mid_after_nwr", 64'(wr_q.size() - wr_base), 64'd0);
        check("mid_after_state", 64'({mem_valid, busy}), 64'd0);

        // Start pulsed during FETCH of the second instruction is ignored.
        clear_rom();
        for (int i = 0; i < 8; i++) put_word(8'(2 * i), vecs[0].prog[i]);
        start_run();
        repeat (3) tick();
        start = 1'b1;
        tick();
        start = 1'b0;
        check("sb_count_kept", 64'(instr_count), 64'd1);
        wait_done("sb", 100);
        check("sb_done", 64'(done_total - done_base), 64'd1);
        check("sb_count", 64'(instr_count), 64'd5);
        check("sb_wr", 64'(get_wr(wr_base)), 64'h0010_00ABCDEF);
        check("sb_nwr", 64'(wr_q.size() - wr_base), 64'd1);

        // Random programs with random backpressure against the interpreter.
        rand_ready = 1'b1;
        for (int t = 0; t < 25; t++) begin
            clear_rom();
            n = $urandom_range(3, 12);
            for (int i = 0; i < n; i++) begin
                opd = 12'($urandom);
                case ($urandom_range(0, 9))
                    0, 1:    op = OP_SHL;
                    2:       op = OP_CLR;
                    3, 4:    op = OP_ST;
                    5, 6:    op = OP_STI;
                    7:       op = OP_NOP;
                    8:       begin op = OP_JMP; opd = {4'($urandom), 8'(2 * $urandom_range(i + 1, n))}; end
                    default: op = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(6, 14)) : OP_STI;
                endcase
                put_word(8'(2 * i), {op, opd});
            end
            put_word(8'(2 * n), 16'hF000);
            model_run(ecnt, eerr);
            start_run();
            wait_done("rnd", 3000);
            check("rnd_nwr", 64'(wr_q.size() - wr_base), 64'(exp_q.size()));
            for (int k = 0; k < exp_q.size(); k++) check("rnd_wr", 64'(get_wr(wr_base + k)), 64'(exp_q[k]));
            check("rnd_count", 64'(instr_count), 64'(ecnt));
            check("rnd_error", 64'(error), 64'(eerr));
            check("rnd_done", 64'(done_total - done_base), 64'd1);
        end
        rand_ready = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/accel_engine.md
Name: accel_engine

Overview:
- Parametrised successor of the fixed rom/state_machine/decoder/memory accelerator chain.
- Folds fetch, multi-word instruction assembly and decode into one engine.
- Adds an immediate-building data register, jumps, halt/illegal-opcode handling and an output FIFO.
- Writes to the memory port over a valid/ready handshake instead of a single start strobe.
- Sits between the instruction ROM and the data memory inside the accelerator top.

Parameters:
- ROM_AW, 8: instruction ROM address width.
- ROM_DW, 8: ROM word width.
- IW, 16: instruction width; must be a multiple of ROM_DW. K = IW/ROM_DW words per instruction.
- MEM_AW, 16: memory address width; must be at least IW-4.
- MEM_DW, 32: memory data width.
- FIFO_DEPTH, 4: output FIFO entries; power of two, at least 2.

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-low reset
- start  in  1  run request, sampled only in IDLE
- rom_addr  out  ROM_AW  ROM address; combinational ROM, rom_data valid same cycle
- rom_data  in  ROM_DW  ROM read data
- mem_valid  out  1  write request valid (FIFO non-empty)
- mem_ready  in  1  memory accepts the head entry this cycle
- mem_addr  out  MEM_AW  head entry address
- mem_wdata  out  MEM_DW  head entry data
- busy  out  1  high in every state except IDLE
- done  out  1  one-cycle pulse at normal completion
- error  out  1  sticky illegal-opcode flag; cleared by the next accepted start
- instr_count  out  16  executed-instruction count; wraps; cleared on accepted start

Behaviour:
- Reset (reset=0, asynchronous): state IDLE, pc=0, data register=0, FIFO empty, instr_count=0.
  - All outputs are 0 during reset, including rom_addr, mem_valid, mem_addr, mem_wdata, busy, done and error.
  - Reset asserted mid-operation aborts the run and discards all FIFO contents.
- Instruction format: opcode = instr[IW-1:IW-4]; operand = instr[IW-5:0], OW = IW-4 bits.
- Word assembly: the first fetched word is the most significant. Word j is read at pc+j, all modulo 2^ROM_AW (pc wraps).
- States:
  - IDLE: rom_addr=pc. start=1 -> pc=0, data register=0, error=0, instr_count=0, go to FETCH. start while busy is ignored.
  - FETCH: K cycles, one word latched per cycle; rom_addr=pc+j; then go to EXEC.
  - EXEC: one cycle unless stalled. instr_count increments when the instruction retires. pc+=K except JMP.
  - DRAIN: wait until the FIFO is empty, then go to DONE.
  - DONE: done=1 for one cycle, then go to IDLE.
- Opcodes:
  - 0x0 NOP: no effect.
  - 0x1 SHL: data = ((data << OW) | operand), truncated to MEM_DW.
  - 0x2 CLR: data = 0.
  - 0x3 ST: push {zero-extended operand, data} into the FIFO.
    - If the FIFO is full, EXEC stalls: no retire, no count, pc held.
    - A pop in the same cycle does not unblock the push (full test uses the registered count).
  - 0x4 STI: as ST, then data = data+1 (mod 2^MEM_DW).
  - 0x5 JMP: pc = operand[ROM_AW-1:0], zero-extended if OW < ROM_AW.
  - 0xF HALT: retires, go to DRAIN.
  - Any other opcode: error=1, counted, go to DRAIN.
- FIFO:
  - A pop occurs when mem_valid && mem_ready.
  - Head entry is registered and held stable while mem_valid=1 && mem_ready=0.
  - A push in EXEC at cycle N makes mem_valid high at N+1 if the FIFO was empty.
  - Push and pop in the same cycle are both honoured when not full.
- Throughput without stalls: K+1 cycles per instruction.
- Infinite loop (JMP to self) never terminates; only reset recovers it.

Decomposition:
- Package accel_pkg: opcode localparams (OP_NOP, OP_SHL, OP_CLR, OP_ST, OP_STI, OP_JMP, OP_HALT) and the state enum (IDLE, FETCH, EXEC, DRAIN, DONE).
- One sub-module: accel_fifo.
  - Parameters: width MEM_AW+MEM_DW, depth FIFO_DEPTH.
  - Ports: push/pop, full/empty, registered head.
  - Same clk/reset convention as the engine.

Test Plan (defaults):
1. Basic store.
   - ROM[0..9] = 20 00 1A BC 1D EF 30 10 F0 00; start pulse; mem_ready=1.
   - Expect exactly one write, addr 0x0010, data 0x00ABCDEF.
   - mem_valid first high 13 cycles after the start edge; done pulse; instr_count=5; error=0.
2. Backpressure.
   - Program: six STI to addr 0x001 after CLR; mem_ready=0 until cycle 40.
   - Expect a stall with 4 entries queued, then writes with data 0,1,2,3,4,5 in order.
   - mem_addr/mem_wdata stable while stalled; no loss or duplication.
3. JMP wrap.
   - ROM[0]=0x50FE (JMP 0xFE); ROM[0xFE..0x01] = F0 00 ...; pc reaches 0xFE.
   - HALT is fetched from 0xFE/0xFF; done asserted; no writes.
4. Illegal opcode.
   - Program 0x7123 followed by other instructions.
   - Expect error=1, instr_count=1, done pulse, no writes.
   - A second start clears error.
5. Reset mid-run.
   - Assert reset with 2 FIFO entries pending and mem_ready=0.
   - Expect mem_valid=0 and busy=0 immediately (asynchronous); state IDLE.
   - No writes after release until a new start.
6. Start while busy.
   - Pulse start again during FETCH.
   - Run is unaffected; instr_count is not cleared; exactly one done pulse.
